// File: rtl/combo_input_sequencer.sv
// Replays one of four hard-coded button combos as timed press/gap pulses.
// Every output is registered; the decode runs on the next-state values, so pulses align with state.
module combo_input_sequencer #(
  parameter int unsigned PRESS_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] combo_sel,
  input  logic       abort,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       attack,
  output logic       block,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StPress, StGap, StDone} state_e;

  // Button one-hot ordering: {up, down, left, right, attack, block}.
  localparam logic [5:0] BtnUp     = 6'b100000;
  localparam logic [5:0] BtnDown   = 6'b010000;
  localparam logic [5:0] BtnLeft   = 6'b001000;
  localparam logic [5:0] BtnRight  = 6'b000100;
  localparam logic [5:0] BtnAttack = 6'b000010;
  localparam logic [5:0] BtnBlock  = 6'b000001;

  localparam logic [CNT_W-1:0] PressLast = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLast   = CNT_W'(GAP_CYCLES - 1);

  function automatic logic [5:0] step_btns(input logic [1:0] sel, input logic [1:0] step);
    logic [5:0] b;
    b = '0;
    unique case (sel)
      2'd0: begin
        unique case (step)
          2'd0:    b = BtnLeft;
          2'd1:    b = BtnDown;
          2'd2:    b = BtnRight;
          default: b = BtnAttack;
        endcase
      end
      2'd1: begin
        unique case (step)
          2'd0:    b = BtnDown;
          2'd1:    b = BtnRight;
          default: b = BtnAttack;
        endcase
      end
      2'd2: begin
        unique case (step)
          2'd0:    b = BtnRight;
          2'd1:    b = BtnDown;
          2'd2:    b = BtnLeft;
          default: b = BtnAttack;
        endcase
      end
      default: begin
        unique case (step)
          2'd0:    b = BtnDown;
          2'd1:    b = BtnDown;
          2'd2:    b = BtnBlock;
          default: b = BtnAttack;
        endcase
      end
    endcase
    return b;
  endfunction

  function automatic logic [1:0] last_step(input logic [1:0] sel);
    return (sel == 2'd1) ? 2'd2 : 2'd3;
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       btns_q, btns_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      // DONE also accepts start so a replay can launch at the edge ending the done pulse.
      StIdle, StDone: begin
        step_d = '0;
        cnt_d  = '0;
        if (start && !abort) begin
          state_d = StPress;
          sel_d   = combo_sel;
        end else begin
          state_d = StIdle;
        end
      end
      StPress: begin
        if (abort) begin
          state_d = StIdle;
          step_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q == PressLast) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StGap: begin
        if (abort) begin
          state_d = StIdle;
          step_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (step_q == last_step(sel_q)) begin
            state_d = StDone;
          end else begin
            state_d = StPress;
            step_d  = step_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    btns_d = (state_d == StPress) ? step_btns(sel_d, step_d) : 6'b0;
    busy_d = (state_d == StPress) || (state_d == StGap);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      btns_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      btns_q  <= btns_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign {up, down, left, right, attack, block} = btns_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_combo_input_sequencer.sv
// Directed bench for combo_input_sequencer with PRESS_CYCLES=2, GAP_CYCLES=3.
module tb_combo_input_sequencer;

  localparam int P   = 2;
  localparam int G   = 3;
  localparam int PER = P + G;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [1:0] combo_sel;
  logic       up, down, left, right, attack, block, busy, done;

  int compared   = 0;
  int mismatched = 0;

  combo_input_sequencer #(
    .PRESS_CYCLES(P),
    .GAP_CYCLES  (G),
    .CNT_W       (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .combo_sel(combo_sel),
    .abort    (abort),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .attack   (attack),
    .block    (block),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // {up, down, left, right, attack, block, busy, done}
  function automatic logic [7:0] obs();
    return {up, down, left, right, attack, block, busy, done};
  endfunction

  // Hand-written combo table: one-hot {up,down,left,right,attack,block}.
  function automatic logic [5:0] tbl(input int sel, input int k);
    case (sel)
      0: case (k) 0: return 6'b001000; 1: return 6'b010000; 2: return 6'b000100;
                  default: return 6'b000010; endcase
      1: case (k) 0: return 6'b010000; 1: return 6'b000100; default: return 6'b000010; endcase
      2: case (k) 0: return 6'b000100; 1: return 6'b010000; 2: return 6'b001000;
                  default: return 6'b000010; endcase
      default: case (k) 0: return 6'b010000; 1: return 6'b010000; 2: return 6'b000001;
                  default: return 6'b000010; endcase
    endcase
  endfunction

  // Expected outputs in cycle c of a replay launched by start sampled at edge 0.
  function automatic logic [7:0] exp_out(input int sel, input int c);
    int len;
    len = (sel == 1) ? 3 : 4;
    if (c >= 1 && c <= len * PER) begin
      if (((c - 1) % PER) < P) return {tbl(sel, (c - 1) / PER), 2'b10};
      return 8'b00000010;
    end
    if (c == len * PER + 1) return 8'b00000001;
    return 8'b0;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; combo_sel = 2'd0;
    repeat (3) @(negedge clk);
    compared++;
    if (obs() !== 8'b0) begin
      mismatched++;
      $display("FAIL reset_state: got %b want %b", obs(), 8'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (obs() !== 8'b0) begin
      mismatched++;
      $display("FAIL idle_after_reset: got %b want %b", obs(), 8'b0);
    end
  endtask

  task automatic test_sel(input int sel);
    int len;
    logic [7:0] e;
    len = (sel == 1) ? 3 : 4;
    start = 1'b1; combo_sel = sel[1:0];
    for (int c = 1; c <= len * PER + 2; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      e = exp_out(sel, c);
      compared++;
      if (obs() !== e) begin
        mismatched++;
        $display("FAIL sel%0d_cycle%0d: got %b want %b", sel, c, obs(), e);
      end
    end
  endtask

  // down,down must show two distinct rising edges separated by a low gap.
  task automatic test_sel3_edges();
    int down_rises, block_rises;
    logic down_p, block_p;
    down_rises = 0; block_rises = 0; down_p = 1'b0; block_p = 1'b0;
    start = 1'b1; combo_sel = 2'd3;
    for (int c = 1; c <= 4 * PER + 2; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (down && !down_p) down_rises++;
      if (block && !block_p) block_rises++;
      down_p = down; block_p = block;
      if (c == 4) begin
        compared++;
        if (down !== 1'b0) begin
          mismatched++;
          $display("FAIL sel3_gap_low: got %b want 0", down);
        end
      end
    end
    compared++;
    if (down_rises != 2 || block_rises != 1) begin
      mismatched++;
      $display("FAIL sel3_edges: got down=%0d block=%0d want down=2 block=1",
               down_rises, block_rises);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    start = 1'b1; combo_sel = 2'd0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      e = exp_out(0, c);
      compared++;
      if (obs() !== e) begin
        mismatched++;
        $display("FAIL b2b_first_cycle%0d: got %b want %b", c, obs(), e);
      end
      if (c == 4) begin start = 1'b1; combo_sel = 2'd2; end
      if (c == 5) start = 1'b0;
      if (c == 21) start = 1'b1;
    end
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      e = exp_out(2, c);
      compared++;
      if (obs() !== e) begin
        mismatched++;
        $display("FAIL b2b_second_cycle%0d: got %b want %b", c, obs(), e);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] e;
    start = 1'b1; combo_sel = 2'd0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      e = (c <= 7) ? exp_out(0, c) : 8'b0;
      compared++;
      if (obs() !== e) begin
        mismatched++;
        $display("FAIL abort_cycle%0d: got %b want %b", c, obs(), e);
      end
      if (c == 7) abort = 1'b1;
      if (c == 8) abort = 1'b0;
    end
    start = 1'b1; abort = 1'b1; combo_sel = 2'd1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      compared++;
      if (obs() !== 8'b0) begin
        mismatched++;
        $display("FAIL start_abort_idle%0d: got %b want %b", c, obs(), 8'b0);
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [7:0] e;
    start = 1'b1; combo_sel = 2'd0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      e = (c <= 12) ? exp_out(0, c) : 8'b0;
      compared++;
      if (obs() !== e) begin
        mismatched++;
        $display("FAIL midreset_cycle%0d: got %b want %b", c, obs(), e);
      end
      if (c == 12) reset = 1'b1;
      if (c == 13) reset = 1'b0;
    end
    test_sel(0);
  endtask

  initial begin
    test_reset();
    test_sel(0);
    test_sel(1);
    test_sel(2);
    test_sel(3);
    test_sel3_edges();
    test_back_to_back();
    test_abort();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
